// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed hex display scanner.
// Provides nibble type, width constants and nibble extraction.
package display_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 16;
    localparam int WIDE_W     = NIBBLE_W * MAX_DIGITS;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    function automatic nibble_t nib_at(
        input logic [WIDE_W-1:0] word,
        input int                i
    );
        return word[NIBBLE_W*i +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescale counter producing a one-cycle step every PRESCALE clocks.
// Ports: clk, reset (async, active-high), tick (high when count = PRESCALE-1).
module tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexes a hex word onto one seven-segment decoder input.
// Ports: clk, reset, data_in, load, lzb_en -> value, digit_en (active-low), frame.
module display_scan
    import display_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NIBBLE_W*NDIGITS-1:0] data_in,
    input  logic                      load,
    input  logic                      lzb_en,
    output logic [NIBBLE_W-1:0]       value,
    output logic [NDIGITS-1:0]        digit_en,
    output logic                      frame
);

    localparam int W  = NIBBLE_W * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

    logic          step;
    logic          boundary;
    logic [IW-1:0] idx;
    logic [W-1:0]  pending;
    logic          pending_valid;
    logic [W-1:0]  display;
    logic [WIDE_W-1:0] wide;
    logic          upper_nz;
    logic          blank;
    nibble_t       cur;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (step)
    );

    assign boundary = step && (idx == LAST_IDX);
    assign wide     = WIDE_W'(display);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (step) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
    end

    // A coincident load lands in pending after the swap has taken the
    // old pending word, so pending_valid stays set for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending       <= '0;
            pending_valid <= 1'b0;
            display       <= '0;
        end else begin
            if (boundary && pending_valid) begin
                display <= pending;
            end
            if (load) begin
                pending       <= data_in;
                pending_valid <= 1'b1;
            end else if (boundary) begin
                pending_valid <= 1'b0;
            end
        end
    end

    // Digit idx is blanked when it and every more significant nibble are
    // zero; digit 0 always stays lit.
    always_comb begin
        upper_nz = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (i >= int'(idx) && nib_at(wide, i) != '0) begin
                upper_nz = 1'b1;
            end
        end
        blank = lzb_en && (idx != '0) && !upper_nz;
        cur   = nib_at(wide, int'(idx));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value    <= '0;
            digit_en <= '1;
            frame    <= 1'b0;
        end else begin
            frame <= boundary;
            if (blank) begin
                value    <= '0;
                digit_en <= '1;
            end else begin
                value    <= cur;
                digit_en <= ~(NDIGITS'(1) << idx);
            end
        end
    end

endmodule
